// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator with per-frame slew limiting, frame-aligned
// pulse width/enable updates and a free-running ADC sample-clock strobe.
module servo_pwm_array #(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned FRAME_TICKS = 1_000_000,
   parameter int unsigned MIN_TICKS   = 50_000,
   parameter int unsigned SPAN_TICKS  = 50_000,
   parameter int unsigned SLEW_STEP   = 4,
   parameter int unsigned CENTER      = 128,
   parameter int unsigned ADC_DIV     = 78,
   localparam int unsigned CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [7:0]          pos_data_i,
   input  logic [CW-1:0]       pos_ch_i,
   input  logic                pos_valid_i,
   output logic                pos_ready_o,
   output logic                ch_err_o,
   input  logic [CHANNELS-1:0] enable_i,
   output logic [CHANNELS-1:0] pwm_out_o,
   output logic                frame_start_o,
   output logic                adc_clk_en_o
);

   localparam int unsigned CntW  = $clog2(FRAME_TICKS);
   localparam int unsigned AdcW  = $clog2(ADC_DIV);
   localparam int unsigned SpanW = $clog2(SPAN_TICKS + 1);
   localparam int unsigned ProdW = SpanW + 9;
   localparam logic signed [8:0] Step = 9'(SLEW_STEP);

   logic [CntW-1:0]     frame_cnt_q, frame_cnt_d;
   logic [AdcW-1:0]     adc_cnt_q, adc_cnt_d;
   logic [7:0]          target_q [CHANNELS];
   logic [7:0]          target_d [CHANNELS];
   logic [7:0]          cur_q    [CHANNELS];
   logic [7:0]          cur_d    [CHANNELS];
   logic [CntW-1:0]     pulse_q  [CHANNELS];
   logic [CntW-1:0]     pulse_d  [CHANNELS];
   logic [CHANNELS-1:0] en_q, en_d, pwm_q, pwm_d;
   logic                frame_start_q, frame_start_d;
   logic                ch_err_q, ch_err_d;
   logic                wrap, accept, in_range;

   // The (p >> 7) term stretches 0..255 onto 0..256 so 255 lands exactly on full span.
   function automatic logic [CntW-1:0] width_f(input logic [7:0] p);
      logic [8:0]       scaled;
      logic [ProdW-1:0] prod;
      scaled = {1'b0, p} + {8'd0, p[7]};
      prod   = ProdW'(scaled) * ProdW'(SPAN_TICKS);
      return CntW'(MIN_TICKS) + CntW'(prod >> 8);
   endfunction

   function automatic logic [7:0] slew_f(input logic [7:0] tgt, input logic [7:0] cur);
      logic signed [8:0] diff;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      if (diff > Step) begin
         return cur + 8'(SLEW_STEP);
      end else if (diff < -Step) begin
         return cur - 8'(SLEW_STEP);
      end
      return tgt;
   endfunction

   assign wrap        = (frame_cnt_q == CntW'(FRAME_TICKS - 1));
   assign pos_ready_o = !rst_i && !wrap;
   assign accept      = pos_valid_i && pos_ready_o;
   assign in_range    = (32'(pos_ch_i) < CHANNELS);

   always_comb begin
      frame_cnt_d   = wrap ? '0 : frame_cnt_q + CntW'(1);
      adc_cnt_d     = (adc_cnt_q == AdcW'(ADC_DIV - 1)) ? '0 : adc_cnt_q + AdcW'(1);
      frame_start_d = (frame_cnt_q == '0);
      ch_err_d      = accept && !in_range;
      target_d      = target_q;
      cur_d         = cur_q;
      pulse_d       = pulse_q;
      en_d          = wrap ? enable_i : en_q;
      pwm_d         = '0;
      for (int n = 0; n < int'(CHANNELS); n++) begin
         if (accept && in_range && (pos_ch_i == CW'(n))) begin
            target_d[n] = pos_data_i;
         end
         if (wrap) begin
            cur_d[n]   = slew_f(target_q[n], cur_q[n]);
            pulse_d[n] = width_f(cur_d[n]);
         end
         pwm_d[n] = en_q[n] && (frame_cnt_q < pulse_q[n]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_cnt_q   <= '0;
         adc_cnt_q     <= '0;
         en_q          <= '0;
         pwm_q         <= '0;
         frame_start_q <= 1'b0;
         ch_err_q      <= 1'b0;
         for (int n = 0; n < int'(CHANNELS); n++) begin
            target_q[n] <= 8'(CENTER);
            cur_q[n]    <= 8'(CENTER);
            pulse_q[n]  <= width_f(8'(CENTER));
         end
      end else begin
         frame_cnt_q   <= frame_cnt_d;
         adc_cnt_q     <= adc_cnt_d;
         en_q          <= en_d;
         pwm_q         <= pwm_d;
         frame_start_q <= frame_start_d;
         ch_err_q      <= ch_err_d;
         target_q      <= target_d;
         cur_q         <= cur_d;
         pulse_q       <= pulse_d;
      end
   end

   assign pwm_out_o     = pwm_q;
   assign frame_start_o = frame_start_q;
   assign ch_err_o      = ch_err_q;
   assign adc_clk_en_o  = (adc_cnt_q == AdcW'(ADC_DIV - 1));

endmodule

// File: tb/tb_servo_pwm_array.sv
// Scoreboard bench: expected per-channel high times are queued before each
// measured frame and compared once the frame has been counted.
module tb_servo_pwm_array;

   localparam int FT = 1000;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] pd1, pd2;
   logic [1:0] pc1;
   logic [2:0] pc2;
   logic       pv1, pv2;
   logic       pr1, pr2, err1, err2, fs1, fs2, adc1, adc2;
   logic [3:0] en1, pwm1;
   logic [4:0] en2, pwm2;

   int tests = 0;
   int fails = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   servo_pwm_array #(
      .CHANNELS(4), .FRAME_TICKS(1000), .MIN_TICKS(100), .SPAN_TICKS(256),
      .SLEW_STEP(4), .CENTER(128), .ADC_DIV(78)
   ) dut (
      .clk_i(clk), .rst_i(rst), .pos_data_i(pd1), .pos_ch_i(pc1), .pos_valid_i(pv1),
      .pos_ready_o(pr1), .ch_err_o(err1), .enable_i(en1), .pwm_out_o(pwm1),
      .frame_start_o(fs1), .adc_clk_en_o(adc1)
   );

   servo_pwm_array #(
      .CHANNELS(5), .FRAME_TICKS(1000), .MIN_TICKS(100), .SPAN_TICKS(256),
      .SLEW_STEP(255), .CENTER(128), .ADC_DIV(78)
   ) dut_fast (
      .clk_i(clk), .rst_i(rst), .pos_data_i(pd2), .pos_ch_i(pc2), .pos_valid_i(pv2),
      .pos_ready_o(pr2), .ch_err_o(err2), .enable_i(en2), .pwm_out_o(pwm2),
      .frame_start_o(fs2), .adc_clk_en_o(adc2)
   );

   // Independent form of the width law for SPAN_TICKS = 256.
   function automatic int exp_w(input int p);
      return 100 + p + ((p >= 128) ? 1 : 0);
   endfunction

   task automatic push4(input int a, input int b, input int c, input int d);
      exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
   endtask

   task automatic push5(input int a, input int b, input int c, input int d, input int e);
      push4(a, b, c, d); exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Counts high cycles of one whole frame starting at the next frame_start.
   task automatic measure(input bit sel, input string name, input int chg_at,
                          input logic [3:0] chg_en);
      int hi[5];
      int n;
      int nch;
      logic [4:0] pw;
      nch = sel ? 5 : 4;
      foreach (hi[c]) hi[c] = 0;
      n = 0;
      while (((sel ? fs2 : fs1) !== 1'b1) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         tests++;
         fails++;
         $display("FAIL %s: frame_start not seen within 3000 cycles", name);
      end
      for (int i = 0; i < FT; i++) begin
         pw = sel ? pwm2 : {1'b0, pwm1};
         for (int c = 0; c < 5; c++) if (pw[c] === 1'b1) hi[c]++;
         if (i == chg_at) en1 = chg_en;
         @(negedge clk);
      end
      for (int c = 0; c < nch; c++) begin
         int e;
         e = exp_q.pop_front();
         tests++;
         if (hi[c] !== e) begin
            fails++;
            $display("FAIL %s ch%0d: high %0d cycles, expected %0d", name, c, hi[c], e);
         end
      end
   endtask

   task automatic do_write(input bit sel, input int ch, input int data);
      int n = 0;
      if (sel) begin
         pv2 = 1'b1; pc2 = 3'(ch); pd2 = 8'(data);
      end else begin
         pv1 = 1'b1; pc1 = 2'(ch); pd1 = 8'(data);
      end
      while (((sel ? pr2 : pr1) !== 1'b1) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         tests++;
         fails++;
         $display("FAIL write: pos_ready stuck low, got 0, expected 1");
      end
      @(negedge clk);
      pv1 = 1'b0;
      pv2 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset pwm_out", int'(pwm1), 0);
      chk("reset frame_start", int'(fs1), 0);
      chk("reset adc_clk_en", int'(adc1), 0);
      chk("reset ch_err", int'(err1), 0);
      chk("reset pos_ready", int'(pr1), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("first frame_start", int'(fs1), 1);
      chk("ready after reset", int'(pr1), 1);
      push4(0, 0, 0, 0);
      measure(1'b0, "frame0 dark", -1, 4'hF);
      push4(229, 229, 229, 229);
      measure(1'b0, "frame1 center", -1, 4'hF);
   endtask

   task automatic test_slew;
      do_write(1'b0, 2, 140);
      push4(229, 229, exp_w(132), 229);
      measure(1'b0, "slew step1", -1, 4'hF);
      push4(229, 229, exp_w(136), 229);
      measure(1'b0, "slew step2", -1, 4'hF);
      push4(229, 229, exp_w(140), 229);
      measure(1'b0, "slew step3", -1, 4'hF);
      push4(229, 229, exp_w(140), 229);
      measure(1'b0, "slew settled", -1, 4'hF);
   endtask

   task automatic test_enable;
      push4(229, 229, 241, 229);
      measure(1'b0, "disable mid-pulse", 100, 4'b0111);
      push4(229, 229, 241, 0);
      measure(1'b0, "disabled frame", -1, 4'hF);
      push4(229, 229, 241, 0);
      measure(1'b0, "re-enable mid-frame", 50, 4'b1111);
      push4(229, 229, 241, 229);
      measure(1'b0, "re-enabled frame", -1, 4'hF);
   endtask

   task automatic test_adc;
      int g = 0;
      while (adc1 !== 1'b1 && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("adc first strobe seen", int'(g < 200), 1);
      for (int k = 0; k < 5; k++) begin
         g = 0;
         do begin
            @(negedge clk);
            g++;
         end while (adc1 !== 1'b1 && g < 200);
         chk("adc strobe period", g, 78);
      end
   endtask

   task automatic test_fast;
      do_write(1'b1, 0, 50);
      do_write(1'b1, 0, 0);
      do_write(1'b1, 1, 255);
      push5(exp_w(0), exp_w(255), 229, 229, 229);
      measure(1'b1, "no slew limit", -1, 4'hF);
   endtask

   task automatic test_ch_err;
      repeat (998) @(negedge clk);
      pv2 = 1'b1; pc2 = 3'd5; pd2 = 8'd0;
      chk("ready low at cnt 999", int'(pr2), 0);
      @(negedge clk);
      chk("ready high at cnt 0", int'(pr2), 1);
      chk("no ch_err before accept", int'(err2), 0);
      @(negedge clk);
      chk("ch_err pulse", int'(err2), 1);
      pv2 = 1'b0;
      @(negedge clk);
      chk("ch_err single cycle", int'(err2), 0);
      push5(exp_w(0), exp_w(255), 229, 229, 229);
      measure(1'b1, "bad write no effect", -1, 4'hF);
   endtask

   task automatic test_reset_mid;
      int n = 0;
      while (fs1 !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("frame_start before mid reset", int'(n < 3000), 1);
      repeat (149) @(negedge clk);
      chk("pwm high before mid reset", int'(pwm1), 15);
      rst = 1'b1;
      @(negedge clk);
      chk("mid reset pwm_out", int'(pwm1), 0);
      chk("mid reset fast pwm_out", int'(pwm2), 0);
      chk("mid reset frame_start", int'(fs1), 0);
      chk("mid reset adc_clk_en", int'(adc1), 0);
      chk("mid reset pos_ready", int'(pr1), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("frame_start after mid reset", int'(fs1), 1);
      push4(0, 0, 0, 0);
      measure(1'b0, "post-reset dark", -1, 4'hF);
      push4(229, 229, 229, 229);
      measure(1'b0, "post-reset center", -1, 4'hF);
      push5(229, 229, 229, 229, 229);
      measure(1'b1, "post-reset fast center", -1, 4'hF);
   endtask

   initial begin
      rst = 1'b1;
      pv1 = 1'b0; pv2 = 1'b0;
      pc1 = '0;   pc2 = '0;
      pd1 = '0;   pd2 = '0;
      en1 = 4'hF; en2 = 5'h1F;
      test_reset;
      test_slew;
      test_enable;
      test_adc;
      test_fast;
      test_ch_err;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
